// File: rtl/jesd204_lane_pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jesd204_lane_pattern_pkg
//  Purpose  : Shared constants, types and helpers for the single-lane
//             JESD204B 8b10b pattern generator: control characters, FSM
//             state encoding and the ILAS configuration/octet builders.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package jesd204_lane_pattern_pkg;

  // 8b10b control characters
  localparam logic [7:0] K28_0 = 8'h1C;  // ILAS multiframe start (R)
  localparam logic [7:0] K28_3 = 8'h7C;  // ILAS multiframe end (A)
  localparam logic [7:0] K28_4 = 8'h9C;  // ILAS config marker (Q)
  localparam logic [7:0] K28_5 = 8'hBC;  // code group sync (K)

  // Number of link configuration octets carried in the second ILAS multiframe
  localparam int ILAS_CFG_OCTETS = 14;

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } lane_state_e;

  // Link configuration octet idx (0..13). Only LID, F-1, K-1 and the
  // fixed N/N'/JESDV fields are non-zero; octet 13 is their 8-bit sum.
  function automatic logic [7:0] cfg_octet(input int         idx,
                                           input logic [4:0] lane_id,
                                           input logic [7:0] f_m1,
                                           input logic [7:0] k_m1);
    logic [7:0] lid;
    logic [7:0] res;
    lid = {3'b000, lane_id};
    res = 8'h00;
    case (idx)
      2:       res = lid;
      4:       res = f_m1;
      5:       res = k_m1;
      7:       res = 8'h0F;
      8:       res = 8'h0F;
      9:       res = 8'h20;
      13:      res = lid + f_m1 + k_m1 + 8'h0F + 8'h0F + 8'h20;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  // One ILAS octet as {is_k, octet} for a given beat and lane position.
  // Stream position 4*beat+lane; config octets occupy positions 2..15
  // of the config multiframe, right after the R and Q characters.
  function automatic logic [8:0] ilas_octet(input int         beat,
                                            input int         lane,
                                            input int         bpm,
                                            input logic       is_cfg_mf,
                                            input logic [4:0] lane_id,
                                            input logic [7:0] f_m1,
                                            input logic [7:0] k_m1);
    int         pos;
    logic [8:0] res;
    pos = 4 * beat + lane;
    res = 9'h000;
    if (beat == 0 && lane == 0) begin
      res = {1'b1, K28_0};
    end else if (beat == bpm - 1 && lane == 3) begin
      res = {1'b1, K28_3};
    end else if (is_cfg_mf) begin
      if (pos == 1) begin
        res = {1'b1, K28_4};
      end else if (pos >= 2 && pos < 2 + ILAS_CFG_OCTETS) begin
        res = {1'b0, cfg_octet(pos - 2, lane_id, f_m1, k_m1)};
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jesd204_lane_pattern_lmfc.sv
`default_nettype none
// ============================================================================
//  Module   : jesd204_lane_pattern_lmfc
//  Purpose  : Free-running LMFC beat counter (0..BEATS_PER_MULTIFRAME-1)
//             with a multiframe-start flag decoded from the registered count.
//  Ports    : clk, reset     - link clock, synchronous active-high reset
//             count_o        - current beat index within the multiframe
//             count_next_o   - value the counter takes on the next edge
//             lmfc_edge_o    - high while count_o == 0
//  Revision : 1.0 - initial release
// ============================================================================
module jesd204_lane_pattern_lmfc #(
  parameter int BEATS_PER_MULTIFRAME = 64,
  parameter int CNT_W = (BEATS_PER_MULTIFRAME > 1) ? $clog2(BEATS_PER_MULTIFRAME) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_o,
  output logic             lmfc_edge_o
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_MULTIFRAME - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = (count_q == LAST_BEAT) ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  // During reset the counter lands on 0 regardless of count_d.
  assign count_next_o = reset ? '0 : count_d;
  assign lmfc_edge_o  = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/jesd204_rx_lane_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : jesd204_rx_lane_pattern_gen
//  Purpose  : Single-lane JESD204B transmit emulator feeding a jesd204_rx
//             link layer: CGS (K28.5) until SYNC~ is released on an LMFC
//             boundary, then ILAS multiframes, then an octet ramp.
//  Ports    : clk, reset        - link clock (4 octets/beat), sync. reset
//             sync              - SYNC~ from the receiver (low = CGS request)
//             cfg_lane_id       - LID placed in the ILAS config octets
//             inject_err        - (JESD204_LANE_PATTERN_ERR_INJECT_EN only)
//                                 corrupt the next DATA beat
//             phy_data          - 4 octets, [7:0] first in time
//             phy_charisk       - per-octet K flag
//             phy_disperr       - per-octet disparity error flag
//             phy_notintable    - per-octet not-in-table flag (always 0)
//             lmfc_edge         - high on beat 0 of each multiframe
//             status_state      - 0 CGS, 1 ILAS, 2 DATA
//  Options  : `define JESD204_LANE_PATTERN_ERR_INJECT_EN adds inject_err.
//  Revision : 1.0 - initial release
// ============================================================================
module jesd204_rx_lane_pattern_gen
  import jesd204_lane_pattern_pkg::*;
#(
  parameter int OCTETS_PER_FRAME      = 8,
  parameter int FRAMES_PER_MULTIFRAME = 32,
  parameter int ILAS_MULTIFRAMES      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync,
  input  logic [4:0]  cfg_lane_id,
`ifdef JESD204_LANE_PATTERN_ERR_INJECT_EN
  input  logic        inject_err,
`endif
  output logic [31:0] phy_data,
  output logic [3:0]  phy_charisk,
  output logic [3:0]  phy_disperr,
  output logic [3:0]  phy_notintable,
  output logic        lmfc_edge,
  output logic [1:0]  status_state
);

  localparam int BPM   = OCTETS_PER_FRAME * FRAMES_PER_MULTIFRAME / 4;
  localparam int CNT_W = (BPM > 1) ? $clog2(BPM) : 1;
  localparam int MF_W  = (ILAS_MULTIFRAMES > 1) ? $clog2(ILAS_MULTIFRAMES) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BPM - 1);
  localparam logic [MF_W-1:0]  LAST_MF   = MF_W'(ILAS_MULTIFRAMES - 1);
  localparam logic [MF_W-1:0]  CFG_MF    = MF_W'(1);
  localparam logic [7:0]       CFG_F_M1  = 8'(OCTETS_PER_FRAME - 1);
  localparam logic [7:0]       CFG_K_M1  = 8'(FRAMES_PER_MULTIFRAME - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  lane_state_e      state_q, state_d;
  logic [MF_W-1:0]  mf_q, mf_d;
  logic [7:0]       ramp_q, ramp_d;     // octet-0 value of the beat on the wire

  logic [31:0]      data_q, data_d;
  logic [3:0]       charisk_q, charisk_d;
  logic [3:0]       disperr_q, disperr_d;

  logic [8:0]       ilas_oct [4];
  logic             inject_w;

  jesd204_lane_pattern_lmfc #(
    .BEATS_PER_MULTIFRAME (BPM),
    .CNT_W                (CNT_W)
  ) u_lmfc (
    .clk          (clk),
    .reset        (reset),
    .count_o      (cnt_q),
    .count_next_o (cnt_d),
    .lmfc_edge_o  (lmfc_edge)
  );

  // ---------------------------------------------------------------------------
  // FSM next state. Outputs are built from the *next* state and beat so that
  // the first ILAS beat lands on the same edge the LMFC counter wraps to 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mf_d    = mf_q;
    ramp_d  = ramp_q;
    case (state_q)
      ST_CGS: begin
        mf_d   = '0;
        ramp_d = 8'h00;
        if (sync && cnt_q == LAST_BEAT) begin
          state_d = ST_ILAS;
        end
      end
      ST_ILAS: begin
        if (!sync) begin
          state_d = ST_CGS;
          mf_d    = '0;
        end else if (cnt_q == LAST_BEAT) begin
          if (mf_q == LAST_MF) begin
            state_d = ST_DATA;
            mf_d    = '0;
            ramp_d  = 8'h00;
          end else begin
            mf_d = mf_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (!sync) begin
          state_d = ST_CGS;
          ramp_d  = 8'h00;
        end else begin
          ramp_d = ramp_q + 8'd4;
        end
      end
      default: begin
        state_d = ST_CGS;
        mf_d    = '0;
        ramp_d  = 8'h00;
      end
    endcase
  end

  // ILAS octets for the upcoming beat, one per lane position
  for (genvar gi = 0; gi < 4; gi++) begin : g_ilas_octet
    assign ilas_oct[gi] = ilas_octet(int'(cnt_d), gi, BPM, (mf_d == CFG_MF),
                                     cfg_lane_id, CFG_F_M1, CFG_K_M1);
  end

`ifdef JESD204_LANE_PATTERN_ERR_INJECT_EN
  // Only corrupt a beat that is itself a DATA beat.
  assign inject_w = inject_err && (state_q == ST_DATA) && (state_d == ST_DATA);
`else
  assign inject_w = 1'b0;
`endif

  always_comb begin
    data_d    = {4{K28_5}};
    charisk_d = 4'b1111;
    disperr_d = {3'b000, inject_w};
    case (state_d)
      ST_ILAS: begin
        data_d    = {ilas_oct[3][7:0], ilas_oct[2][7:0], ilas_oct[1][7:0], ilas_oct[0][7:0]};
        charisk_d = {ilas_oct[3][8], ilas_oct[2][8], ilas_oct[1][8], ilas_oct[0][8]};
      end
      ST_DATA: begin
        data_d    = {ramp_d + 8'd3, ramp_d + 8'd2, ramp_d + 8'd1, ramp_d};
        charisk_d = 4'b0000;
        data_d[0] = data_d[0] ^ inject_w;
      end
      default: begin
        data_d    = {4{K28_5}};
        charisk_d = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CGS;
      mf_q      <= '0;
      ramp_q    <= 8'h00;
      data_q    <= {4{K28_5}};
      charisk_q <= 4'b1111;
      disperr_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      mf_q      <= mf_d;
      ramp_q    <= ramp_d;
      data_q    <= data_d;
      charisk_q <= charisk_d;
      disperr_q <= disperr_d;
    end
  end

  assign phy_data       = data_q;
  assign phy_charisk    = charisk_q;
  assign phy_disperr    = disperr_q;
  assign phy_notintable = 4'b0000;
  assign status_state   = state_q;

endmodule
`default_nettype wire
